nmr_seq_table_engine: RTL

//  Table-driven NMR pulse sequencer. It replaces the fixed T1/90/180/echo FSM with a programmable list of segments.

---
 rtl/nmr_seq_table_engine.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/nmr_seq_table_engine.sv
// Table-driven NMR pulse sequencer: a programmable segment list with a loop range
// drives the phase-cycled TX H-bridge, the ADC clock and the acquisition window.
module nmr_seq_table_engine #(
  parameter int unsigned SEG_DEPTH    = 16,
  parameter int unsigned DUR_WIDTH    = 32,
  parameter int unsigned LOOP_WIDTH   = 16,
  parameter int unsigned TX_DIV_LOG2  = 4,
  parameter int unsigned ADC_DIV_LOG2 = 2,
  localparam int unsigned AW = $clog2(SEG_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  seg_wr_en_i,
  input  logic [AW-1:0]         seg_wr_addr_i,
  input  logic [DUR_WIDTH+3:0]  seg_wr_data_i,
  input  logic [AW:0]           seq_len_i,
  input  logic [AW-1:0]         loop_start_i,
  input  logic [AW-1:0]         loop_end_i,
  input  logic [LOOP_WIDTH-1:0] loop_count_i,
  input  logic [1:0]            phase_ofs_i,
  input  logic [DUR_WIDTH-1:0]  tail_delay_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  fsmstat_o,
  output logic                  done_o,
  output logic                  cfg_err_o,
  output logic [AW-1:0]         seg_idx_o,
  output logic                  acq_wnd_o,
  output logic                  adc_clk_o,
  output logic                  tx_out_p_o,
  output logic                  tx_out_n_o
);

  localparam int unsigned TW = (TX_DIV_LOG2 > ADC_DIV_LOG2) ? TX_DIV_LOG2 : ADC_DIV_LOG2;

  typedef struct packed {
    logic [DUR_WIDTH-1:0] dur;
    logic                 tx_en;
    logic [1:0]           ph;
    logic                 acq;
  } seg_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_TAIL,
    S_FIN
  } state_t;

  state_t                state_q, state_d;
  seg_t                  table_q [SEG_DEPTH];
  logic [DUR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LOOP_WIDTH-1:0] loop_rem_q, loop_rem_d;
  logic [AW:0]           seq_len_q, seq_len_d;
  logic [AW-1:0]         loop_start_q, loop_start_d;
  logic [AW-1:0]         loop_end_q, loop_end_d;
  logic [1:0]            phase_ofs_q, phase_ofs_d;
  logic [DUR_WIDTH-1:0]  tail_q, tail_d;
  logic [AW-1:0]         seg_idx_q, seg_idx_d;
  logic                  out_en_q, out_en_d;
  logic [1:0]            ph_q, ph_d;
  logic                  acq_q, acq_d;
  logic                  fsmstat_q, fsmstat_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  tx_p_q, tx_p_d;
  logic                  tx_n_q, tx_n_d;
  logic                  adc_q, adc_d;

  logic                  cfg_bad;
  logic                  last_seg;
  logic                  load_seg;
  logic [AW-1:0]         next_idx;
  logic [1:0]            ofs_use;
  logic [1:0]            quad_d;
  seg_t                  entry;

  assign cfg_bad  = (seq_len_i == '0) ||
                    (seq_len_i > (AW+1)'(SEG_DEPTH)) ||
                    ({1'b0, loop_end_i} >= seq_len_i) ||
                    (loop_start_i > loop_end_i);
  assign last_seg = ({1'b0, seg_idx_q} == (seq_len_q - (AW+1)'(1)));

  // Segment table; not reset, and frozen while a sequence is active.
  always_ff @(posedge clk_i) begin
    if (seg_wr_en_i && !fsmstat_q) begin
      table_q[seg_wr_addr_i] <= seg_t'(seg_wr_data_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      loop_rem_q   <= '0;
      seq_len_q    <= '0;
      loop_start_q <= '0;
      loop_end_q   <= '0;
      phase_ofs_q  <= '0;
      tail_q       <= '0;
      seg_idx_q    <= '0;
      out_en_q     <= 1'b0;
      ph_q         <= '0;
      acq_q        <= 1'b0;
      fsmstat_q    <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      timer_q      <= '0;
      tx_p_q       <= 1'b0;
      tx_n_q       <= 1'b0;
      adc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      loop_rem_q   <= loop_rem_d;
      seq_len_q    <= seq_len_d;
      loop_start_q <= loop_start_d;
      loop_end_q   <= loop_end_d;
      phase_ofs_q  <= phase_ofs_d;
      tail_q       <= tail_d;
      seg_idx_q    <= seg_idx_d;
      out_en_q     <= out_en_d;
      ph_q         <= ph_d;
      acq_q        <= acq_d;
      fsmstat_q    <= fsmstat_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      timer_q      <= timer_d;
      tx_p_q       <= tx_p_d;
      tx_n_q       <= tx_n_d;
      adc_q        <= adc_d;
    end
  end

  // Next state; every output register is computed from the next-cycle values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    loop_rem_d   = loop_rem_q;
    seq_len_d    = seq_len_q;
    loop_start_d = loop_start_q;
    loop_end_d   = loop_end_q;
    phase_ofs_d  = phase_ofs_q;
    tail_d       = tail_q;
    seg_idx_d    = seg_idx_q;
    out_en_d     = out_en_q;
    ph_d         = ph_q;
    acq_d        = acq_q;
    fsmstat_d    = fsmstat_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    load_seg     = 1'b0;
    next_idx     = seg_idx_q;
    ofs_use      = phase_ofs_q;
    entry        = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        seq_len_d    = seq_len_i;
        loop_start_d = loop_start_i;
        loop_end_d   = loop_end_i;
        phase_ofs_d  = phase_ofs_i;
        tail_d       = tail_delay_i;
        loop_rem_d   = (loop_count_i == '0) ? '0 : loop_count_i - LOOP_WIDTH'(1);
        fsmstat_d    = 1'b1;
        if (abort_i) begin
          state_d  = S_FIN;
          out_en_d = 1'b0;
          acq_d    = 1'b0;
        end else begin
          state_d  = S_RUN;
          load_seg = 1'b1;
          next_idx = '0;
          ofs_use  = phase_ofs_i;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d  = S_FIN;
          out_en_d = 1'b0;
          acq_d    = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DUR_WIDTH'(1);
        end else if ((seg_idx_q == loop_end_q) && (loop_rem_q != '0)) begin
          load_seg   = 1'b1;
          next_idx   = loop_start_q;
          loop_rem_d = loop_rem_q - LOOP_WIDTH'(1);
        end else if (last_seg) begin
          out_en_d = 1'b0;
          acq_d    = 1'b0;
          if (tail_q != '0) begin
            state_d = S_TAIL;
            cnt_d   = tail_q - DUR_WIDTH'(1);
          end else begin
            state_d = S_FIN;
          end
        end else begin
          load_seg = 1'b1;
          next_idx = seg_idx_q + AW'(1);
        end
      end
      S_TAIL: begin
        if (abort_i || (cnt_q == '0)) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - DUR_WIDTH'(1);
        end
      end
      S_FIN: begin
        state_d   = S_IDLE;
        fsmstat_d = 1'b0;
        done_d    = 1'b1;
        seg_idx_d = '0;
        out_en_d  = 1'b0;
        acq_d     = 1'b0;
        ph_d      = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // A zero-duration entry still occupies one cycle, with TX and ACQ forced off.
    entry = table_q[next_idx];
    if (load_seg) begin
      seg_idx_d = next_idx;
      ph_d      = entry.ph + ofs_use;
      if (entry.dur == '0) begin
        out_en_d = 1'b0;
        acq_d    = 1'b0;
        cnt_d    = '0;
      end else begin
        out_en_d = entry.tx_en;
        acq_d    = entry.acq;
        cnt_d    = entry.dur - DUR_WIDTH'(1);
      end
    end

    timer_d = (fsmstat_d && fsmstat_q) ? timer_q + TW'(1) : '0;
    quad_d  = timer_d[TX_DIV_LOG2-1 -: 2] + ph_d;
    tx_p_d  = out_en_d & quad_d[1];
    tx_n_d  = out_en_d & ~quad_d[1];
    adc_d   = timer_d[ADC_DIV_LOG2-1];
  end

  assign fsmstat_o  = fsmstat_q;
  assign done_o     = done_q;
  assign cfg_err_o  = cfg_err_q;
  assign seg_idx_o  = seg_idx_q;
  assign acq_wnd_o  = acq_q;
  assign adc_clk_o  = adc_q;
  assign tx_out_p_o = tx_p_q;
  assign tx_out_n_o = tx_n_q;

endmodule
